vga_timing_rx: RTL

//  Receive end of the VGA timing interface: samples HVsync/RGB from a vga-style generator (or an external source), recovers

---
 rtl/vga_timing_rx.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_rx.sv
// rtl/vga_timing_rx.sv - VGA timing receiver: sync recovery, line/frame measurement, lock tracking, pixel probe
// Pixel position is recovered from synchronised sync edges. Lock is declared after LOCK_FRAMES consecutive clean frames.
module vga_timing_rx #(
  parameter int H_DISPLAY       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_DISPLAY       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int SYNC_STAGES     = 2,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        display_on,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] h_meas,
  output logic [9:0]  v_meas,
  output logic [2:0]  probe_rgb,
  output logic        probe_valid,
  output logic [7:0]  lost_cnt
);

  localparam int          H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int          V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [10:0] H_START   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END     = 11'(H_SYNC + H_BACK + H_DISPLAY - 1);
  localparam logic [9:0]  V_START   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_END     = 10'(V_SYNC + V_BACK + V_DISPLAY - 1);
  localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [10:0] H_TIMEOUT = 11'(2 * H_TOTAL);
  localparam logic [3:0]  LOCK_W    = 4'(LOCK_FRAMES);
  localparam logic        INACTIVE  = SYNC_ACTIVE_LOW;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  logic [SYNC_STAGES-1:0]      hs_sync_q, hs_sync_d;
  logic [SYNC_STAGES-1:0]      vs_sync_q, vs_sync_d;
  logic [SYNC_STAGES-1:0][2:0] rgb_sync_q, rgb_sync_d;
  logic                        hs_prev_q, vs_prev_q;
  logic [2:0]                  rgb_al_q;

  state_t      state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        vpend_q, vpend_d;
  logic        frame_err_q, frame_err_d;
  logic        locked_q, locked_d;
  logic [7:0]  lost_q, lost_d;
  logic [10:0] h_meas_q, h_meas_d;
  logic [9:0]  v_meas_q, v_meas_d;
  logic        frame_start_q, frame_start_d;
  logic [2:0]  probe_rgb_q, probe_rgb_d;
  logic        probe_valid_q, probe_valid_d;

  logic hs_act, hs_prev_act, vs_act, vs_prev_act;
  logic hs_edge, vs_edge, fs_evt, line_bad, frame_ok, timeout, lose;
  logic in_win, probe_hit;

  // Shift registers for the input synchronisers.
  always_comb begin
    hs_sync_d     = hs_sync_q;
    vs_sync_d     = vs_sync_q;
    rgb_sync_d    = rgb_sync_q;
    hs_sync_d[0]  = hsync;
    vs_sync_d[0]  = vsync;
    rgb_sync_d[0] = rgb;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      hs_sync_d[i]  = hs_sync_q[i-1];
      vs_sync_d[i]  = vs_sync_q[i-1];
      rgb_sync_d[i] = rgb_sync_q[i-1];
    end
  end

  always_comb begin
    hs_act      = hs_sync_q[SYNC_STAGES-1] ^ SYNC_ACTIVE_LOW;
    hs_prev_act = hs_prev_q ^ SYNC_ACTIVE_LOW;
    vs_act      = vs_sync_q[SYNC_STAGES-1] ^ SYNC_ACTIVE_LOW;
    vs_prev_act = vs_prev_q ^ SYNC_ACTIVE_LOW;
    hs_edge     = hs_act & ~hs_prev_act;
    vs_edge     = vs_act & ~vs_prev_act;
    fs_evt      = hs_edge & (vpend_q | vs_edge);
    line_bad    = hs_edge & (({1'b0, hcnt_q} + 12'd1) != H_TOTAL_W);
    // The line closing at the frame-start edge belongs to the frame being judged.
    frame_ok    = ~(frame_err_q | line_bad) & (({1'b0, vcnt_q} + 11'd1) == V_TOTAL_W);
    timeout     = ~hs_edge & (hcnt_q >= H_TIMEOUT);
  end

  // Line/frame counters and measurements.
  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    vpend_d       = vpend_q;
    frame_err_d   = frame_err_q;
    h_meas_d      = h_meas_q;
    v_meas_d      = v_meas_q;
    frame_start_d = fs_evt;
    if (hs_edge) begin
      h_meas_d = (&hcnt_q) ? hcnt_q : hcnt_q + 11'd1;
      hcnt_d   = '0;
    end else if (!(&hcnt_q)) begin
      hcnt_d = hcnt_q + 11'd1;
    end
    if (fs_evt) begin
      v_meas_d = (&vcnt_q) ? vcnt_q : vcnt_q + 10'd1;
      vcnt_d   = '0;
      vpend_d  = 1'b0;
    end else begin
      if (hs_edge && !(&vcnt_q)) vcnt_d = vcnt_q + 10'd1;
      if (vs_edge) vpend_d = 1'b1;
    end
    if (fs_evt) frame_err_d = 1'b0;
    else if (line_bad) frame_err_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    lose    = 1'b0;
    if (timeout) begin
      state_d = SEARCH;
      good_d  = '0;
      lose    = (state_q == LOCKED);
    end else begin
      case (state_q)
        SEARCH: begin
          if (fs_evt) begin
            state_d = TRACK;
            good_d  = '0;
          end
        end
        TRACK: begin
          if (fs_evt) begin
            if (frame_ok) begin
              good_d = good_q + 4'd1;
              if (good_q + 4'd1 == LOCK_W) state_d = LOCKED;
            end else begin
              good_d = '0;
            end
          end
        end
        LOCKED: begin
          if ((fs_evt && !frame_ok) || line_bad) begin
            state_d = TRACK;
            good_d  = '0;
            lose    = 1'b1;
          end
        end
        default: begin
          state_d = SEARCH;
          good_d  = '0;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
    lost_d   = (lose && lost_q != 8'hff) ? lost_q + 8'd1 : lost_q;
  end

  always_comb begin
    in_win     = (hcnt_q >= H_START) && (hcnt_q <= H_END) &&
                 (vcnt_q >= V_START) && (vcnt_q <= V_END);
    display_on = locked_q & in_win;
    hpos       = display_on ? 10'(hcnt_q - H_START) : 10'd0;
    vpos       = display_on ? 10'(vcnt_q - V_START) : 10'd0;
    // rgb_al_q carries the pixel that belongs to the current hcnt/vcnt.
    probe_hit     = display_on && (hpos == probe_x) && (vpos == probe_y);
    probe_rgb_d   = probe_hit ? rgb_al_q : probe_rgb_q;
    probe_valid_d = probe_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_sync_q     <= {SYNC_STAGES{INACTIVE}};
      vs_sync_q     <= {SYNC_STAGES{INACTIVE}};
      rgb_sync_q    <= '0;
      hs_prev_q     <= INACTIVE;
      vs_prev_q     <= INACTIVE;
      rgb_al_q      <= '0;
      state_q       <= SEARCH;
      good_q        <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      vpend_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      locked_q      <= 1'b0;
      lost_q        <= '0;
      h_meas_q      <= '0;
      v_meas_q      <= '0;
      frame_start_q <= 1'b0;
      probe_rgb_q   <= '0;
      probe_valid_q <= 1'b0;
    end else begin
      hs_sync_q     <= hs_sync_d;
      vs_sync_q     <= vs_sync_d;
      rgb_sync_q    <= rgb_sync_d;
      hs_prev_q     <= hs_sync_q[SYNC_STAGES-1];
      vs_prev_q     <= vs_sync_q[SYNC_STAGES-1];
      rgb_al_q      <= rgb_sync_q[SYNC_STAGES-1];
      state_q       <= state_d;
      good_q        <= good_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      vpend_q       <= vpend_d;
      frame_err_q   <= frame_err_d;
      locked_q      <= locked_d;
      lost_q        <= lost_d;
      h_meas_q      <= h_meas_d;
      v_meas_q      <= v_meas_d;
      frame_start_q <= frame_start_d;
      probe_rgb_q   <= probe_rgb_d;
      probe_valid_q <= probe_valid_d;
    end
  end

  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign h_meas      = h_meas_q;
  assign v_meas      = v_meas_q;
  assign probe_rgb   = probe_rgb_q;
  assign probe_valid = probe_valid_q;
  assign lost_cnt    = lost_q;

endmodule
